// File: rtl/adc_cond_pkg.sv
// adc_cond_pkg: shared types and constants for the ADC conditioning stage.
//   cond_state_e   - conditioner FSM states (calibrating / running)
//   DacMid         - midscale offset added to the signed sample for the monitor DAC
//   sat_pos/sat_neg - symmetric saturation limits for a signed sample width
//   acc_width      - calibration accumulator width for a sample width and average length
package adc_cond_pkg;

  typedef enum logic [0:0] {
    StCal = 1'b0,
    StRun = 1'b1
  } cond_state_e;

  localparam int DacMid = 8191;

  // Largest positive value of a signed data_w-bit sample.
  function automatic int sat_pos(input int unsigned data_w);
    return (1 << (data_w - 1)) - 1;
  endfunction

  // Symmetric negative limit: the most negative code is never produced.
  function automatic int sat_neg(input int unsigned data_w);
    return -sat_pos(data_w);
  endfunction

  // Holds the sum of 2**cal_log2 signed data_w-bit samples without overflow.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned cal_log2);
    return data_w + cal_log2;
  endfunction

endpackage

// File: rtl/adc_conditioner_moving_average.sv
// moving_average: boxcar average over the last 2**AVG_LOG2 accepted samples.
//   clock, reset_n - clock and synchronous active-low reset
//   clear          - empty the window and zero the running sum
//   in_valid       - in_data holds a new sample
//   in_data        - signed sample
//   out_valid      - one-cycle strobe, one cycle after in_valid
//   out_data       - running sum arithmetically shifted by AVG_LOG2 (floor)
// AVG_LOG2 must be at least 1.
module moving_average #(
  parameter int unsigned DATA_W   = 14,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data
);

  localparam int unsigned N     = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = DATA_W + AVG_LOG2;

  logic signed [DATA_W-1:0] window_q [N];
  logic signed [DATA_W-1:0] window_d [N];
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic signed [DATA_W-1:0] avg_q, avg_d;
  logic                     valid_q, valid_d;

  always_comb begin
    window_d = window_q;
    sum_d    = sum_q;
    avg_d    = avg_q;
    valid_d  = 1'b0;
    if (clear) begin
      window_d = '{default: '0};
      sum_d    = '0;
    end else if (in_valid) begin
      window_d[0] = in_data;
      for (int unsigned i = 1; i < N; i++) begin
        window_d[i] = window_q[i-1];
      end
      // Wraparound in the intermediate is harmless: the final sum always fits SUM_W.
      sum_d   = sum_q + {{AVG_LOG2{in_data[DATA_W-1]}}, in_data}
                      - {{AVG_LOG2{window_q[N-1][DATA_W-1]}}, window_q[N-1]};
      avg_d   = sum_d[SUM_W-1:AVG_LOG2];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      window_q <= '{default: '0};
      sum_q    <= '0;
      avg_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      window_q <= window_d;
      sum_q    <= sum_d;
      avg_q    <= avg_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = avg_q;

endmodule

// File: rtl/adc_conditioner.sv
// adc_conditioner: per-channel ADC front end ahead of the control law.
// Calibrates a DC offset from 2**CAL_LOG2 samples, then emits the sign-inverted,
// offset-corrected, symmetrically saturated and boxcar-averaged sample.
//   i_clock, i_RESET - 100 MHz clock, synchronous active-low reset
//   i_valid/i_data/i_or - sample strobe, signed sample, ADC out-of-range bit
//   i_cal_req   - restart offset calibration (wins over a coincident sample)
//   i_or_clear  - clear o_or_sticky, o_fault and the out-of-range run counter
//   o_value/o_valid - conditioned sample and its strobe (two cycles after i_valid)
//   o_dac       - offset-binary copy of o_value for the monitor DAC
//   o_offset    - offset currently subtracted
//   o_cal_busy  - calibration in progress
//   o_or_sticky - any out-of-range sample seen while running
//   o_fault     - OR_LIMIT consecutive out-of-range samples seen while running
// CAL_LOG2 must be at least 1.
module adc_conditioner
  import adc_cond_pkg::*;
#(
  parameter int unsigned DATA_W   = 14,
  parameter int unsigned CAL_LOG2 = 10,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned OR_LIMIT = 16
) (
  input  logic                     i_clock,
  input  logic                     i_RESET,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_or,
  input  logic                     i_cal_req,
  input  logic                     i_or_clear,
  output logic signed [DATA_W-1:0] o_value,
  output logic                     o_valid,
  output logic        [DATA_W-1:0] o_dac,
  output logic signed [DATA_W-1:0] o_offset,
  output logic                     o_cal_busy,
  output logic                     o_or_sticky,
  output logic                     o_fault
);

  localparam int unsigned ACC_W  = acc_width(DATA_W, CAL_LOG2);
  localparam int unsigned DIFF_W = DATA_W + 2;
  localparam int unsigned OR_W   = $clog2(OR_LIMIT + 1);

  localparam logic signed [DIFF_W-1:0] SAT_P   = DIFF_W'(sat_pos(DATA_W));
  localparam logic signed [DIFF_W-1:0] SAT_N   = DIFF_W'(sat_neg(DATA_W));
  localparam logic        [DATA_W-1:0] DAC_MID = DATA_W'(DacMid);
  localparam logic        [OR_W-1:0]   OR_LIM  = OR_W'(OR_LIMIT);

  cond_state_e state_q, state_d;

  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic        [CAL_LOG2-1:0] cal_cnt_q, cal_cnt_d;
  logic signed [DATA_W-1:0] offset_q, offset_d;
  logic                     cal_done;
  logic                     accept;

  logic signed [DIFF_W-1:0] diff, clip;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [DATA_W-1:0] s1_data_q, s1_data_d;

  logic [OR_W-1:0] or_cnt_q, or_cnt_d;
  logic            sticky_q, sticky_d;
  logic            fault_q, fault_d;

  // A calibration request discards any coincident sample.
  assign accept   = i_valid & ~i_cal_req;
  assign cal_done = (state_q == StCal) & accept & (cal_cnt_q == '1);

  // ---------------------------------------------------------------------------
  // FSM: state register, next state, outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (!i_RESET) begin
      state_q <= StCal;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCal: begin
        if (!i_cal_req && cal_done) state_d = StRun;
      end
      StRun: begin
        if (i_cal_req) state_d = StCal;
      end
      default: state_d = StCal;
    endcase
  end

  always_comb begin
    o_cal_busy = (state_q == StCal);
  end

  // ---------------------------------------------------------------------------
  // Offset calibration
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_sum   = acc_q + {{CAL_LOG2{i_data[DATA_W-1]}}, i_data};
    acc_d     = acc_q;
    cal_cnt_d = cal_cnt_q;
    offset_d  = offset_q;
    if (i_cal_req) begin
      acc_d     = '0;
      cal_cnt_d = '0;
    end else if (cal_done) begin
      // Upper bits of the sum are the floor of the mean.
      offset_d  = acc_sum[ACC_W-1:CAL_LOG2];
      acc_d     = '0;
      cal_cnt_d = '0;
    end else if ((state_q == StCal) && i_valid) begin
      acc_d     = acc_sum;
      cal_cnt_d = cal_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_RESET) begin
      acc_q     <= '0;
      cal_cnt_q <= '0;
      offset_q  <= '0;
    end else begin
      acc_q     <= acc_d;
      cal_cnt_q <= cal_cnt_d;
      offset_q  <= offset_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: sign-inverting offset subtraction and symmetric saturation
  // ---------------------------------------------------------------------------
  always_comb begin
    // Board wiring inverts the signal, hence offset minus sample.
    diff = {{2{offset_q[DATA_W-1]}}, offset_q} - {{2{i_data[DATA_W-1]}}, i_data};
    if (diff > SAT_P) begin
      clip = SAT_P;
    end else if (diff < SAT_N) begin
      clip = SAT_N;
    end else begin
      clip = diff;
    end
    s1_data_d  = clip[DATA_W-1:0];
    s1_valid_d = (state_q == StRun) & accept;
  end

  always_ff @(posedge i_clock) begin
    if (!i_RESET) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: moving average, window emptied as calibration completes
  // ---------------------------------------------------------------------------
  moving_average #(
    .DATA_W  (DATA_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clock    (i_clock),
    .reset_n  (i_RESET),
    .clear    (cal_done),
    .in_valid (s1_valid_q),
    .in_data  (s1_data_q),
    .out_valid(o_valid),
    .out_data (o_value)
  );

  // Fixed offset of the registered average, so it changes on the same edge.
  assign o_dac = o_value + DAC_MID;

  // ---------------------------------------------------------------------------
  // Out-of-range tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    or_cnt_d = or_cnt_q;
    sticky_d = sticky_q;
    fault_d  = fault_q;
    if (i_or_clear) begin
      or_cnt_d = '0;
      sticky_d = 1'b0;
      fault_d  = 1'b0;
    end else if ((state_q == StRun) && accept) begin
      if (i_or) begin
        sticky_d = 1'b1;
        if (or_cnt_q != OR_LIM) or_cnt_d = or_cnt_q + 1'b1;
        if (or_cnt_d == OR_LIM) fault_d = 1'b1;
      end else begin
        or_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_RESET) begin
      or_cnt_q <= '0;
      sticky_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      or_cnt_q <= or_cnt_d;
      sticky_q <= sticky_d;
      fault_q  <= fault_d;
    end
  end

  assign o_offset    = offset_q;
  assign o_or_sticky = sticky_q;
  assign o_fault     = fault_q;

endmodule

// File: tb/tb_adc_conditioner.sv
module tb_adc_conditioner;

  localparam int DATA_W   = 14;
  localparam int CAL_LOG2 = 10;
  localparam int AVG_LOG2 = 2;
  localparam int OR_LIMIT = 16;
  localparam int NCAL     = 1 << CAL_LOG2;
  localparam int NWIN     = 1 << AVG_LOG2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     valid = 1'b0;
  logic signed [DATA_W-1:0] data = '0;
  logic                     or_bit = 1'b0;
  logic                     cal_req = 1'b0;
  logic                     or_clear = 1'b0;
  logic signed [DATA_W-1:0] o_value;
  logic                     o_valid;
  logic        [DATA_W-1:0] o_dac;
  logic signed [DATA_W-1:0] o_offset;
  logic                     o_cal_busy;
  logic                     o_or_sticky;
  logic                     o_fault;

  adc_conditioner #(
    .DATA_W  (DATA_W),
    .CAL_LOG2(CAL_LOG2),
    .AVG_LOG2(AVG_LOG2),
    .OR_LIMIT(OR_LIMIT)
  ) dut (
    .i_clock    (clk),
    .i_RESET    (rst_n),
    .i_valid    (valid),
    .i_data     (data),
    .i_or       (or_bit),
    .i_cal_req  (cal_req),
    .i_or_clear (or_clear),
    .o_value    (o_value),
    .o_valid    (o_valid),
    .o_dac      (o_dac),
    .o_offset   (o_offset),
    .o_cal_busy (o_cal_busy),
    .o_or_sticky(o_or_sticky),
    .o_fault    (o_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int value;
    int dac;
    int due;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  bit     m_cal = 1'b1;
  longint m_acc = 0;
  int     m_cnt = 0;
  int     m_off = 0;
  int     m_win[NWIN];

  function automatic int floor_div(input longint a, input int b);
    longint r;
    r = a % b;
    if (r < 0) r += b;
    return int'((a - r) / b);
  endfunction

  function automatic int clip(input int x);
    if (x > 8191) return 8191;
    if (x < -8191) return -8191;
    return x;
  endfunction

  // Scoreboard: every DUT output strobe must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (o_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_valid: got o_valid=1 value=%0d, required no output", o_value);
      end else begin
        e = sb.pop_front();
        if (o_value !== e.value || o_dac !== e.dac || cyc != e.due) begin
          n_fail++;
          $display("FAIL sb_output: got value=%0d dac=%0d cycle=%0d, required value=%0d dac=%0d cycle=%0d",
                   o_value, o_dac, cyc, e.value, e.dac, e.due);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus (starting and ending at a falling edge) and update the model.
  task automatic drive(input bit v, input int d, input bit orb, input bit req, input bit clr);
    int sum;
    exp_t e;
    valid    = v;
    data     = DATA_W'(d);
    or_bit   = orb;
    cal_req  = req;
    or_clear = clr;
    if (req) begin
      m_cal = 1'b1;
      m_acc = 0;
      m_cnt = 0;
    end else if (v) begin
      if (m_cal) begin
        m_acc += d;
        m_cnt++;
        if (m_cnt == NCAL) begin
          m_off = floor_div(m_acc, NCAL);
          m_cal = 1'b0;
          m_acc = 0;
          m_cnt = 0;
          for (int i = 0; i < NWIN; i++) m_win[i] = 0;
        end
      end else begin
        for (int i = NWIN - 1; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = clip(m_off - d);
        sum = 0;
        for (int i = 0; i < NWIN; i++) sum += m_win[i];
        e.value = floor_div(sum, NWIN);
        e.dac   = e.value + 8191;
        e.due   = cyc + 2;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    valid    = 1'b0;
    or_bit   = 1'b0;
    cal_req  = 1'b0;
    or_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic calibrate(input int d);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < NCAL; i++) drive(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset(input string tag);
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    m_cal = 1'b1;
    m_acc = 0;
    m_cnt = 0;
    m_off = 0;
    for (int i = 0; i < NWIN; i++) m_win[i] = 0;
    n_checks++;
    if (o_value !== 0 || o_valid !== 1'b0 || o_dac !== 8191 || o_offset !== 0) begin
      n_fail++;
      $display("FAIL reset_%s_data: got value=%0d valid=%b dac=%0d offset=%0d, required 0 0 8191 0",
               tag, o_value, o_valid, o_dac, o_offset);
    end
    n_checks++;
    if (o_cal_busy !== 1'b1 || o_or_sticky !== 1'b0 || o_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_%s_flags: got busy=%b sticky=%b fault=%b, required 1 0 0",
               tag, o_cal_busy, o_or_sticky, o_fault);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_calibration();
    for (int i = 0; i < NCAL; i++) begin
      drive(1'b1, 100, (i < 20), 1'b0, 1'b0);
      if (i == NCAL - 2) begin
        n_checks++;
        if (o_cal_busy !== 1'b1 || o_offset !== 0) begin
          n_fail++;
          $display("FAIL cal_before_last: got busy=%b offset=%0d, required 1 0", o_cal_busy, o_offset);
        end
      end
    end
    n_checks++;
    if (o_cal_busy !== 1'b0 || o_offset !== 100) begin
      n_fail++;
      $display("FAIL cal_done: got busy=%b offset=%0d, required 0 100", o_cal_busy, o_offset);
    end
    n_checks++;
    if (o_or_sticky !== 1'b0 || o_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL cal_or_ignored: got sticky=%b fault=%b, required 0 0", o_or_sticky, o_fault);
    end
  endtask

  task automatic test_cal_floor();
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < NCAL; i++) drive(1'b1, (i % 2 == 0) ? -3 : -2, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (o_offset !== -3) begin
      n_fail++;
      $display("FAIL cal_floor: got offset=%0d, required -3", o_offset);
    end
  endtask

  task automatic test_conversion();
    calibrate(100);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 600, 1'b0, 1'b0, 1'b0);
      idle(k);
    end
    idle(3);
    n_checks++;
    if (o_value !== -500 || o_dac !== 7691) begin
      n_fail++;
      $display("FAIL conv_settled: got value=%0d dac=%0d, required -500 7691", o_value, o_dac);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) drive(1'b1, int'($urandom_range(0, 16383)) - 8192, 1'b0, 1'b0, 1'b0);
    idle(3);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drained: got %0d outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_saturation();
    calibrate(0);
    for (int i = 0; i < 4; i++) drive(1'b1, -8192, 1'b0, 1'b0, 1'b0);
    idle(3);
    n_checks++;
    if (o_offset !== 0 || o_value !== 8191 || o_dac !== 16382) begin
      n_fail++;
      $display("FAIL sat_min_in: got offset=%0d value=%0d dac=%0d, required 0 8191 16382",
               o_offset, o_value, o_dac);
    end
    calibrate(2000);
    for (int i = 0; i < 4; i++) drive(1'b1, -8000, 1'b0, 1'b0, 1'b0);
    idle(3);
    n_checks++;
    if (o_offset !== 2000 || o_value !== 8191) begin
      n_fail++;
      $display("FAIL sat_pos_clip: got offset=%0d value=%0d, required 2000 8191", o_offset, o_value);
    end
    calibrate(-8192);
    for (int i = 0; i < 4; i++) drive(1'b1, 8191, 1'b0, 1'b0, 1'b0);
    idle(3);
    n_checks++;
    if (o_offset !== -8192 || o_value !== -8191 || o_dac !== 0) begin
      n_fail++;
      $display("FAIL sat_neg_clip: got offset=%0d value=%0d dac=%0d, required -8192 -8191 0",
               o_offset, o_value, o_dac);
    end
  endtask

  task automatic test_or();
    calibrate(100);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < OR_LIMIT - 1; i++) drive(1'b1, 600, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (o_or_sticky !== 1'b1 || o_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL or_15: got sticky=%b fault=%b, required 1 0", o_or_sticky, o_fault);
    end
    drive(1'b1, 600, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (o_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL or_16: got fault=%b, required 1", o_fault);
    end
    for (int i = 0; i < 20; i++) drive(1'b1, 600, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (o_fault !== 1'b1 || o_or_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL or_hold: got sticky=%b fault=%b, required 1 1", o_or_sticky, o_fault);
    end
    drive(1'b1, 600, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (o_or_sticky !== 1'b0 || o_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL or_clear_wins: got sticky=%b fault=%b, required 0 0", o_or_sticky, o_fault);
    end
    for (int i = 0; i < OR_LIMIT - 1; i++) drive(1'b1, 600, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (o_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL or_count_zeroed: got fault=%b, required 0", o_fault);
    end
    drive(1'b1, 600, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (o_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL or_refault: got fault=%b, required 1", o_fault);
    end
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, 600, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 600, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 600, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (o_or_sticky !== 1'b1 || o_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL or_run_broken: got sticky=%b fault=%b, required 1 0", o_or_sticky, o_fault);
    end
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic test_recal();
    calibrate(300);
    drive(1'b1, 500, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 700, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (o_cal_busy !== 1'b1 || o_offset !== 300) begin
      n_fail++;
      $display("FAIL recal_enter: got busy=%b offset=%0d, required 1 300", o_cal_busy, o_offset);
    end
    idle(3);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL recal_inflight: got %0d outstanding, required 0", sb.size());
    end
    for (int i = 0; i < NCAL - 1; i++) drive(1'b1, -40, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (o_cal_busy !== 1'b1 || o_offset !== 300) begin
      n_fail++;
      $display("FAIL recal_hold: got busy=%b offset=%0d, required 1 300", o_cal_busy, o_offset);
    end
    drive(1'b1, -40, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (o_cal_busy !== 1'b0 || o_offset !== -40) begin
      n_fail++;
      $display("FAIL recal_update: got busy=%b offset=%0d, required 0 -40", o_cal_busy, o_offset);
    end
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 500; i++) drive(1'b1, 1000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < NCAL - 1; i++) drive(1'b1, 250, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (o_cal_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL recal_restart_busy: got busy=%b, required 1", o_cal_busy);
    end
    drive(1'b1, 250, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (o_cal_busy !== 1'b0 || o_offset !== 250) begin
      n_fail++;
      $display("FAIL recal_restart: got busy=%b offset=%0d, required 0 250", o_cal_busy, o_offset);
    end
  endtask

  task automatic test_reset_restart();
    idle(3);
    test_reset("mid_run");
    for (int i = 0; i < 300; i++) drive(1'b1, 50, 1'b0, 1'b0, 1'b0);
    test_reset("mid_cal");
    for (int i = 0; i < NCAL - 1; i++) drive(1'b1, 70, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (o_cal_busy !== 1'b1 || o_offset !== 0) begin
      n_fail++;
      $display("FAIL reset_restart_busy: got busy=%b offset=%0d, required 1 0", o_cal_busy, o_offset);
    end
    drive(1'b1, 70, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (o_cal_busy !== 1'b0 || o_offset !== 70) begin
      n_fail++;
      $display("FAIL reset_restart_done: got busy=%b offset=%0d, required 0 70", o_cal_busy, o_offset);
    end
  endtask

  initial begin
    for (int i = 0; i < NWIN; i++) m_win[i] = 0;
    idle(2);
    test_reset("initial");
    test_calibration();
    test_cal_floor();
    test_conversion();
    test_back_to_back();
    test_saturation();
    test_or();
    test_recal();
    test_reset_restart();
    test_back_to_back();
    idle(4);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: got %0d outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
